// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths and the accumulator-to-result saturation helper
package systolic_pkg;
    localparam int DW    = 16;
    localparam int ACCW  = 40;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic          clip;
        logic [DW-1:0] val;
    } sat_t;
    function automatic sat_t saturate(input logic [ACCW-1:0] x);
        sat_t r;
        r.clip = !((&x[ACCW-1:DW-1]) || !(|x[ACCW-1:DW-1]));
        r.val  = r.clip ? {x[ACCW-1], {(DW-1){~x[ACCW-1]}}} : x[DW-1:0];
        return r;
    endfunction
endpackage

// File: rtl/pe_fifo.sv
// pe_fifo: synchronous operand FIFO with head-of-queue read data and occupancy
module pe_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DW-1:0]          din,
    input  logic                   rd_en,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr, rd;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    always_comb begin
        wr       = wr_en && !full;
        rd       = rd_en && !empty;
        mem_d    = mem_q;
        if (wr) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d  = count_q + CW'(wr) - CW'(rd);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: operand-buffered MAC element forwarding operands and emitting a saturated dot product
module systolic_pe #(
    parameter int DW    = systolic_pkg::DW,
    parameter int DEPTH = systolic_pkg::DEPTH,
    parameter int ACCW  = systolic_pkg::ACCW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic          start,
    input  logic          awe,
    input  logic          bwe,
    input  logic          ais,
    input  logic          bis,
    input  logic [7:0]    max_cntr,
    output logic          aff,
    output logic          bff,
    output logic          se,
    output logic          fout,
    output logic          sat,
    output logic [DW-1:0] s_out,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          start_next
);
    import systolic_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [DW-1:0]   a_dout, b_dout;
    logic            a_full, a_empty, b_full, b_empty;
    logic [CW-1:0]   a_count, b_count;
    logic            pop, done;
    logic [2*DW-1:0] a_ext, b_ext, prod;
    sat_t            res;
    logic            busy_q, busy_d, se_q, se_d, fout_q, fout_d, sat_q, sat_d, start_next_q, start_next_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]   s_out_q, s_out_d, a_out_q, a_out_d, b_out_q, b_out_d;
    pe_fifo #(.DW(DW), .DEPTH(DEPTH)) u_a_fifo (
        .clk(clk), .rst(rst), .wr_en(awe), .din(a_in), .rd_en(pop),
        .dout(a_dout), .full(a_full), .empty(a_empty), .count(a_count)
    );
    pe_fifo #(.DW(DW), .DEPTH(DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst), .wr_en(bwe), .din(b_in), .rd_en(pop),
        .dout(b_dout), .full(b_full), .empty(b_empty), .count(b_count)
    );
    always_comb
        assert (a_full == (a_count == CW'(DEPTH)) && a_empty == (a_count == '0) &&
                b_full == (b_count == CW'(DEPTH)) && b_empty == (b_count == '0));
    always_comb begin
        a_ext        = {{DW{a_dout[DW-1]}}, a_dout};
        b_ext        = {{DW{b_dout[DW-1]}}, b_dout};
        prod         = a_ext * b_ext;
        res          = saturate(acc_q);
        pop          = busy_q && cnt_q < max_cntr && !a_empty && !b_empty && !ais && !bis && !start;
        done         = busy_q && cnt_q == max_cntr && !start;
        busy_d       = start || (busy_q && !done);
        cnt_d        = start ? '0 : pop ? cnt_q + 8'd1 : cnt_q;
        acc_d        = start ? '0 : pop ? acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod} : acc_q;
        se_d         = done;
        sat_d        = done ? res.clip : sat_q;
        s_out_d      = done ? res.val : s_out_q;
        fout_d       = pop;
        a_out_d      = pop ? a_dout : a_out_q;
        b_out_d      = pop ? b_dout : b_out_q;
        start_next_d = start;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            se_q         <= 1'b0;
            sat_q        <= 1'b0;
            s_out_q      <= '0;
            fout_q       <= 1'b0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            start_next_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            se_q         <= se_d;
            sat_q        <= sat_d;
            s_out_q      <= s_out_d;
            fout_q       <= fout_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            start_next_q <= start_next_d;
        end
    end
    assign aff        = a_full;
    assign bff        = b_full;
    assign se         = se_q;
    assign sat        = sat_q;
    assign s_out      = s_out_q;
    assign fout       = fout_q;
    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign start_next = start_next_q;
endmodule

// File: tb/tb_systolic_pe.sv
// tb_systolic_pe: table-driven dot products plus directed full, stall, restart and reset sequences
module tb_systolic_pe;
    logic clk = 1'b0;
    logic rst, start, awe, bwe, ais, bis;
    logic signed [15:0] a_in, b_in;
    logic [7:0] max_cntr;
    logic aff, bff, se, fout, sat, start_next;
    logic signed [15:0] s_out, a_out, b_out;
    int checks = 0;
    int failures = 0;
    int pa_q[$];
    int pb_q[$];
    int se_cnt = 0;
    int last_s = 0;
    int last_sat = 0;
    int base;
    typedef struct {
        int n;
        int a[4];
        int b[4];
        int s;
        int st;
    } vec_t;
    vec_t tbl[10];
    always #5 clk = ~clk;
    systolic_pe dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .start(start),
        .awe(awe), .bwe(bwe), .ais(ais), .bis(bis), .max_cntr(max_cntr),
        .aff(aff), .bff(bff), .se(se), .fout(fout), .sat(sat), .s_out(s_out),
        .a_out(a_out), .b_out(b_out), .start_next(start_next)
    );
    always @(negedge clk) begin
        if (fout) begin
            pa_q.push_back(int'(a_out));
            pb_q.push_back(int'(b_out));
        end
        if (se) begin
            se_cnt++;
            last_s = int'(s_out);
            last_sat = int'(sat);
        end
    end
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start(input int n);
        max_cntr = 8'(n);
        pa_q.delete();
        pb_q.delete();
        start = 1'b1;
        tick();
        chk("start_next", int'(start_next), 1);
        start = 1'b0;
        tick();
        chk("start_next_drop", int'(start_next), 0);
    endtask
    task automatic wr(input int a, input bit wa, input int b, input bit wb);
        a_in = 16'(a);
        b_in = 16'(b);
        awe = wa;
        bwe = wb;
        tick();
        awe = 1'b0;
        bwe = 1'b0;
    endtask
    task automatic wait_se(input int b0, input string nm);
        int k = 0;
        while (se_cnt == b0 && k < 40) begin
            tick();
            k++;
        end
        chk({nm, "_se_seen"}, int'(se_cnt > b0), 1);
    endtask
    task automatic chk_pop(input string nm, input int i, input int ea, input int eb);
        chk({nm, "_pop_a"}, (pa_q.size() > i) ? pa_q[i] : -99999, ea);
        chk({nm, "_pop_b"}, (pb_q.size() > i) ? pb_q[i] : -99999, eb);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        tbl[0] = '{4, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 70, 0};
        tbl[1] = '{2, '{32767, 32767, 0, 0}, '{32767, 32767, 0, 0}, 32767, 1};
        tbl[2] = '{2, '{32767, 32767, 0, 0}, '{-32768, -32768, 0, 0}, -32768, 1};
        tbl[3] = '{3, '{-3, 4, -5, 0}, '{7, -2, -1, 0}, -24, 0};
        tbl[4] = '{1, '{100, 0, 0, 0}, '{327, 0, 0, 0}, 32700, 0};
        tbl[5] = '{2, '{200, -100, 0, 0}, '{200, 100, 0, 0}, 30000, 0};
        tbl[6] = '{2, '{181, 6, 0, 0}, '{181, 1, 0, 0}, 32767, 0};
        tbl[7] = '{2, '{-128, 0, 0, 0}, '{256, 0, 0, 0}, -32768, 0};
        tbl[8] = '{2, '{181, 7, 0, 0}, '{181, 1, 0, 0}, 32767, 1};
        tbl[9] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0};
        rst = 1'b1; start = 1'b0; awe = 1'b0; bwe = 1'b0; ais = 1'b0; bis = 1'b0;
        a_in = '0; b_in = '0; max_cntr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_aff", int'(aff), 0);
        chk("rst_bff", int'(bff), 0);
        chk("rst_se", int'(se), 0);
        chk("rst_fout", int'(fout), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_s_out", int'(s_out), 0);
        chk("rst_a_out", int'(a_out), 0);
        chk("rst_b_out", int'(b_out), 0);
        chk("rst_start_next", int'(start_next), 0);
        for (int t = 0; t < 10; t++) begin
            base = se_cnt;
            do_start(tbl[t].n);
            for (int k = 0; k < tbl[t].n; k++) wr(tbl[t].a[k], 1'b1, tbl[t].b[k], 1'b1);
            wait_se(base, $sformatf("v%0d", t));
            repeat (3) tick();
            chk($sformatf("v%0d_se_once", t), se_cnt - base, 1);
            chk($sformatf("v%0d_s_out", t), last_s, tbl[t].s);
            chk($sformatf("v%0d_sat", t), last_sat, tbl[t].st);
            chk($sformatf("v%0d_npops", t), pa_q.size(), tbl[t].n);
            for (int k = 0; k < tbl[t].n; k++) chk_pop($sformatf("v%0d_%0d", t, k), k, tbl[t].a[k], tbl[t].b[k]);
        end
        for (int i = 0; i < 6; i++) begin
            wr(11 + i, 1'b1, 0, 1'b0);
            chk($sformatf("ovf_aff_%0d", i), int'(aff), (i >= 3) ? 1 : 0);
        end
        chk("ovf_bff", int'(bff), 0);
        base = se_cnt;
        do_start(4);
        for (int k = 0; k < 4; k++) wr(0, 1'b0, 1, 1'b1);
        wait_se(base, "ovf");
        chk("ovf_s_out", last_s, 50);
        for (int k = 0; k < 4; k++) chk_pop($sformatf("ovf_%0d", k), k, 11 + k, 1);
        chk("ovf_aff_after", int'(aff), 0);
        base = se_cnt;
        do_start(1);
        wr(0, 1'b0, 3, 1'b1);
        repeat (3) tick();
        chk("ovf_dropped_no_pop", pa_q.size(), 0);
        wr(2, 1'b1, 0, 1'b0);
        wait_se(base, "ovf2");
        chk("ovf2_s_out", last_s, 6);
        chk_pop("ovf2", 0, 2, 3);
        base = se_cnt;
        ais = 1'b1;
        do_start(3);
        wr(2, 1'b1, 5, 1'b1);
        wr(3, 1'b1, 6, 1'b1);
        wr(4, 1'b1, 7, 1'b1);
        repeat (3) tick();
        chk("stall_fout", int'(fout), 0);
        chk("stall_npops", pa_q.size(), 0);
        chk("stall_no_se", se_cnt - base, 0);
        ais = 1'b0;
        wait_se(base, "stall");
        chk("stall_s_out", last_s, 56);
        chk("stall_npops_after", pa_q.size(), 3);
        for (int k = 0; k < 3; k++) chk_pop($sformatf("stall_%0d", k), k, 2 + k, 5 + k);
        base = se_cnt;
        bis = 1'b1;
        do_start(1);
        wr(3, 1'b1, 4, 1'b1);
        repeat (2) tick();
        chk("bstall_npops", pa_q.size(), 0);
        bis = 1'b0;
        wait_se(base, "bstall");
        chk("bstall_s_out", last_s, 12);
        base = se_cnt;
        do_start(4);
        wr(1, 1'b1, 1, 1'b1);
        wr(2, 1'b1, 2, 1'b1);
        repeat (2) tick();
        chk("restart_pre_pops", pa_q.size(), 2);
        do_start(4);
        for (int k = 0; k < 4; k++) wr(3 + k, 1'b1, 1, 1'b1);
        wait_se(base, "restart");
        repeat (3) tick();
        chk("restart_se_once", se_cnt - base, 1);
        chk("restart_s_out", last_s, 18);
        chk("restart_npops", pa_q.size(), 4);
        base = se_cnt;
        do_start(4);
        wr(7, 1'b1, 7, 1'b1);
        wr(8, 1'b1, 8, 1'b1);
        wr(9, 1'b1, 0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_aff", int'(aff), 0);
        chk("mrst_bff", int'(bff), 0);
        chk("mrst_se", int'(se), 0);
        chk("mrst_fout", int'(fout), 0);
        chk("mrst_s_out", int'(s_out), 0);
        chk("mrst_a_out", int'(a_out), 0);
        chk("mrst_b_out", int'(b_out), 0);
        chk("mrst_start_next", int'(start_next), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("mrst_no_se", se_cnt - base, 0);
        do_start(1);
        wr(0, 1'b0, 2, 1'b1);
        repeat (3) tick();
        chk("mrst_fifo_empty", pa_q.size(), 0);
        chk("mrst_no_se_after", se_cnt - base, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
